// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback queue: register-file geometry,
// queue entry payload and result-source encoding.
package wb_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam int unsigned NUM_REGS = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] wa;
        logic [DATA_W-1:0] wd;
    } wb_entry_t;

    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_MEM = 1'b1
    } src_e;

    function automatic src_e other_src(input src_e s);
        return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO of writeback entries; the whole storage array and
// read pointer are exported so the top can search queued results for bypass.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_push,
    input  wb_entry_t                     i_din,
    input  logic                          i_pop,
    output logic [$clog2(DEPTH):0]        o_count,
    output wb_entry_t                     o_head,
    output wb_entry_t [DEPTH-1:0]         o_entries,
    output logic [$clog2(DEPTH)-1:0]      o_rd_ptr
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    wb_entry_t [DEPTH-1:0] r_mem;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [CNT_W-1:0]      r_count;

    // Pointers wrap naturally since DEPTH is a power of two; count tells full from empty.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides which slots are live.
    always_ff @(posedge clock) begin
        if (i_push) r_mem[r_wr_ptr] <= i_din;
    end

    assign o_count   = r_count;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_entries = r_mem;
    assign o_rd_ptr  = r_rd_ptr;

endmodule

// File: rtl/writeback_queue.sv
// Writeback stage feeding the register-file write port: arbitrates ALU/load results,
// queues them in order, retires one per cycle and tracks pending writes. Macro WBQ_BYPASS_EN adds bypass search.
module writeback_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [ADDR_W-1:0]          alu_wa,
    input  logic [DATA_W-1:0]          alu_wd,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [ADDR_W-1:0]          mem_wa,
    input  logic [DATA_W-1:0]          mem_wd,
    input  logic                       drain_en,
    input  logic                       iss_valid,
    input  logic [ADDR_W-1:0]          iss_wa,
    output logic                       rf_we,
    output logic [ADDR_W-1:0]          rf_wa,
    output logic [DATA_W-1:0]          rf_wd,
    output logic [NUM_REGS-1:0]        busy,
    output logic [$clog2(DEPTH):0]     count,
    input  logic [ADDR_W-1:0]          ra0,
    input  logic [ADDR_W-1:0]          ra1,
    output logic                       fwd0_hit,
    output logic                       fwd1_hit,
    output logic [DATA_W-1:0]          fwd0_data,
    output logic [DATA_W-1:0]          fwd1_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    src_e                  r_rr_prio;
    logic [NUM_REGS-1:0]   r_busy;
    logic [NUM_REGS-1:0]   w_busy_nxt;
    logic                  w_grant_alu;
    logic                  w_grant_mem;
    logic                  w_not_full;
    logic                  w_acc_alu;
    logic                  w_acc_mem;
    logic                  w_push;
    logic                  w_pop;
    src_e                  w_acc_src;
    wb_entry_t             w_in;
    wb_entry_t             w_head;
    wb_entry_t [DEPTH-1:0] w_entries;
    logic [PTR_W-1:0]      w_rd_ptr;
    logic [CNT_W-1:0]      w_count;

    // Round-robin grant: a lone requester always wins, a tie goes to the favoured source.
    assign w_grant_alu = alu_valid & (~mem_valid | (r_rr_prio == SRC_ALU));
    assign w_grant_mem = mem_valid & (~alu_valid | (r_rr_prio == SRC_MEM));
    assign w_not_full  = (w_count < CNT_W'(DEPTH));
    assign alu_ready   = reset & w_grant_alu & w_not_full;
    assign mem_ready   = reset & w_grant_mem & w_not_full;
    assign w_acc_alu   = alu_valid & alu_ready;
    assign w_acc_mem   = mem_valid & mem_ready;
    assign w_acc_src   = w_acc_mem ? SRC_MEM : SRC_ALU;
    assign w_in        = w_acc_mem ? wb_entry_t'({mem_wa, mem_wd}) : wb_entry_t'({alu_wa, alu_wd});

    // Writes to r0 complete the handshake but are dropped here.
    assign w_push = (w_acc_alu | w_acc_mem) & (w_in.wa != '0);
    assign w_pop  = reset & drain_en & (w_count != '0);

    always_ff @(posedge clock) begin
        if (!reset)                     r_rr_prio <= SRC_ALU;
        else if (w_acc_alu | w_acc_mem) r_rr_prio <= other_src(w_acc_src);
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .i_push    (w_push),
        .i_din     (w_in),
        .i_pop     (w_pop),
        .o_count   (w_count),
        .o_head    (w_head),
        .o_entries (w_entries),
        .o_rd_ptr  (w_rd_ptr)
    );

    assign rf_we = w_pop;
    assign rf_wa = reset ? w_head.wa : '0;
    assign rf_wd = reset ? w_head.wd : '0;
    assign count = w_count;

    // Retirement clears, dispatch sets; set wins on the same register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) w_busy_nxt[w_head.wa] = 1'b0;
        if (iss_valid && (iss_wa != '0)) w_busy_nxt[iss_wa] = 1'b1;
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clock) begin
        if (!reset) r_busy <= '0;
        else        r_busy <= w_busy_nxt;
    end

    assign busy = r_busy;

`ifdef WBQ_BYPASS_EN
    // Walk oldest to youngest so the last live match is the youngest value.
    always_comb begin
        logic [PTR_W-1:0] idx;
        idx       = '0;
        fwd0_hit  = 1'b0;
        fwd1_hit  = 1'b0;
        fwd0_data = '0;
        fwd1_data = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = w_rd_ptr + PTR_W'(i);
            if (CNT_W'(i) < w_count) begin
                if ((ra0 != '0) && (w_entries[idx].wa == ra0)) begin
                    fwd0_hit  = 1'b1;
                    fwd0_data = w_entries[idx].wd;
                end
                if ((ra1 != '0) && (w_entries[idx].wa == ra1)) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = w_entries[idx].wd;
                end
            end
        end
    end
`else
    logic w_unused;
    assign w_unused  = ^{ra0, ra1, w_entries, w_rd_ptr};
    assign fwd0_hit  = 1'b0;
    assign fwd1_hit  = 1'b0;
    assign fwd0_data = '0;
    assign fwd1_data = '0;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Self-checking bench for writeback_queue: directed scenarios plus randomized traffic
// compared every cycle against a queue-based model of the writeback rules.
module tb_writeback_queue;

    localparam int DEPTH = 4;

    typedef struct {
        bit [4:0]  wa;
        bit [31:0] wd;
    } ent_t;

    logic        clock = 1'b0;
    logic        reset;
    logic        alu_valid, mem_valid, drain_en, iss_valid;
    logic        alu_ready, mem_ready;
    logic [4:0]  alu_wa, mem_wa, iss_wa, ra0, ra1;
    logic [31:0] alu_wd, mem_wd;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;
    logic [31:0] busy;
    logic [2:0]  count;
    logic        fwd0_hit, fwd1_hit;
    logic [31:0] fwd0_data, fwd1_data;

    int checks   = 0;
    int failures = 0;

    ent_t      q[$];
    bit [31:0] m_busy     = '0;
    bit        m_prio_mem = 1'b0;

    always #5 clock = ~clock;

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_wa    (alu_wa),
        .alu_wd    (alu_wd),
        .mem_valid (mem_valid),
        .mem_ready (mem_ready),
        .mem_wa    (mem_wa),
        .mem_wd    (mem_wd),
        .drain_en  (drain_en),
        .iss_valid (iss_valid),
        .iss_wa    (iss_wa),
        .rf_we     (rf_we),
        .rf_wa     (rf_wa),
        .rf_wd     (rf_wd),
        .busy      (busy),
        .count     (count),
        .ra0       (ra0),
        .ra1       (ra1),
        .fwd0_hit  (fwd0_hit),
        .fwd1_hit  (fwd1_hit),
        .fwd0_data (fwd0_data),
        .fwd1_data (fwd1_data)
    );

    // Issue stage may only dispatch to a register that is idle or retiring this cycle.
    always @(posedge clock) begin
        if (reset && iss_valid && iss_wa != 5'd0)
            assert (!busy[iss_wa] || (rf_we && rf_wa == iss_wa))
                else $error("issue dispatched to pending register %0d", iss_wa);
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
        end
    endtask

    // Compare all outputs with the model for the current cycle, then advance the model.
    task automatic cyc();
        bit        g_alu, g_mem, nf, e_ar, e_mr, e_we, h0, h1;
        bit [31:0] d0, d1;
        #1;
        nf    = (q.size() < DEPTH);
        g_alu = alu_valid && (!mem_valid || !m_prio_mem);
        g_mem = mem_valid && (!alu_valid || m_prio_mem);
        e_ar  = reset && g_alu && nf;
        e_mr  = reset && g_mem && nf;
        e_we  = reset && drain_en && (q.size() != 0);
        chk("alu_ready", alu_ready, e_ar);
        chk("mem_ready", mem_ready, e_mr);
        chk("rf_we", rf_we, e_we);
        if (e_we) begin
            chk("rf_wa", rf_wa, q[0].wa);
            chk("rf_wd", rf_wd, q[0].wd);
        end else if (!reset) begin
            chk("rf_wa_rst", rf_wa, 0);
            chk("rf_wd_rst", rf_wd, 0);
        end
        chk("count", count, q.size());
        chk("busy", busy, m_busy);
        h0 = 0; h1 = 0; d0 = 0; d1 = 0;
        foreach (q[i]) begin
            if (ra0 != 0 && q[i].wa == ra0) begin h0 = 1; d0 = q[i].wd; end
            if (ra1 != 0 && q[i].wa == ra1) begin h1 = 1; d1 = q[i].wd; end
        end
`ifdef WBQ_BYPASS_EN
        chk("fwd0_hit", fwd0_hit, h0);
        chk("fwd1_hit", fwd1_hit, h1);
        if (h0) chk("fwd0_data", fwd0_data, d0);
        if (h1) chk("fwd1_data", fwd1_data, d1);
`else
        chk("fwd0_hit", fwd0_hit, 0);
        chk("fwd1_hit", fwd1_hit, 0);
        chk("fwd0_data", fwd0_data, 0);
        chk("fwd1_data", fwd1_data, 0);
        if (h0 || h1) d0 = d1;
`endif
        if (!reset) begin
            q.delete();
            m_busy     = '0;
            m_prio_mem = 1'b0;
        end else begin
            if (e_we) begin
                m_busy[q[0].wa] = 1'b0;
                void'(q.pop_front());
            end
            if (iss_valid && iss_wa != 0) m_busy[iss_wa] = 1'b1;
            if (alu_valid && e_ar) begin
                if (alu_wa != 0) q.push_back('{alu_wa, alu_wd});
                m_prio_mem = 1'b1;
            end else if (mem_valid && e_mr) begin
                if (mem_wa != 0) q.push_back('{mem_wa, mem_wd});
                m_prio_mem = 1'b0;
            end
        end
    endtask

    task automatic next();
        @(negedge clock);
    endtask

    task automatic idle();
        reset = 1; alu_valid = 0; mem_valid = 0; drain_en = 0; iss_valid = 0;
        alu_wa = 0; alu_wd = 0; mem_wa = 0; mem_wd = 0; iss_wa = 0; ra0 = 0; ra1 = 0;
    endtask

    task automatic do_reset();
        idle();
        reset = 0;
        cyc(); next();
        reset = 1;
    endtask

    initial begin
        idle();
        reset = 0;
        next();

        // T1: held reset blocks handshakes, then one-cycle writeback latency
        alu_valid = 1; alu_wa = 5; alu_wd = 32'hDEAD_BEEF; drain_en = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("t1_rst_ready", alu_ready, 0);
            chk("t1_rst_we", rf_we, 0);
            next();
        end
        reset = 1;
        cyc(); chk("t1_accept", alu_ready, 1); next();
        alu_valid = 0;
        cyc();
        chk("t1_we", rf_we, 1);
        chk("t1_wa", rf_wa, 5);
        chk("t1_wd", rf_wd, 32'hDEAD_BEEF);
        chk("t1_count1", count, 1);
        next();
        cyc(); chk("t1_count0", count, 0); chk("t1_we0", rf_we, 0); next();

        // T2: both sources every cycle alternate grants starting with ALU
        do_reset();
        alu_valid = 1; mem_valid = 1; drain_en = 1;
        for (int i = 0; i < 8; i++) begin
            alu_wa = 5'($urandom_range(31, 1)); alu_wd = $urandom;
            mem_wa = 5'($urandom_range(31, 1)); mem_wd = $urandom;
            cyc();
            chk("t2_alu_grant", alu_ready, (i % 2) == 0);
            chk("t2_mem_grant", mem_ready, (i % 2) == 1);
            next();
        end
        alu_valid = 0; mem_valid = 0;
        repeat (3) begin cyc(); next(); end

        // T3: fill while frozen, then drain; ready returns only after the first pop
        do_reset();
        alu_valid = 1;
        for (int i = 0; i < 4; i++) begin
            alu_wa = 5'(i + 1); alu_wd = 32'(i * 111);
            cyc(); next();
        end
        mem_valid = 1; mem_wa = 9; mem_wd = 32'h99;
        cyc();
        chk("t3_full", count, 4);
        chk("t3_alu_nrdy", alu_ready, 0);
        chk("t3_mem_nrdy", mem_ready, 0);
        next();
        drain_en = 1;
        cyc();
        chk("t3_we_a", rf_we, 1);
        chk("t3_rdy_ignores_pop", alu_ready | mem_ready, 0);
        next();
        cyc();
        chk("t3_we_b", rf_we, 1);
        chk("t3_rdy_back", alu_ready | mem_ready, 1);
        next();
        alu_valid = 0; mem_valid = 0;
        cyc(); chk("t3_we_c", rf_we, 1); next();
        cyc(); chk("t3_we_d", rf_we, 1); next();
        repeat (3) begin cyc(); next(); end

        // T4: scoreboard set/clear priority, r0 never tracked or written
        do_reset();
        drain_en = 1; iss_valid = 1; iss_wa = 7;
        cyc(); next();
        iss_valid = 0;
        cyc(); chk("t4_busy7_set", busy[7], 1); next();
        alu_valid = 1; alu_wa = 7; alu_wd = 77;
        cyc(); next();
        alu_valid = 0; iss_valid = 1; iss_wa = 7;
        cyc(); chk("t4_we7", rf_we, 1); chk("t4_wa7", rf_wa, 7); next();
        iss_valid = 0;
        cyc(); chk("t4_busy7_kept", busy[7], 1); next();
        iss_valid = 1; iss_wa = 0;
        cyc(); next();
        iss_valid = 0;
        cyc(); chk("t4_busy0", busy[0], 0); next();
        alu_valid = 1; alu_wa = 0; alu_wd = 123;
        cyc(); chk("t4_r0_accept", alu_ready, 1); next();
        alu_valid = 0;
        cyc(); chk("t4_r0_no_we", rf_we, 0); chk("t4_r0_count", count, 0); next();

        // T5: reset discards queued entries and pending bits
        do_reset();
        mem_valid = 1;
        for (int i = 0; i < 3; i++) begin
            mem_wa = 5'(10 + i); mem_wd = 32'(1000 + i);
            iss_valid = (i == 0); iss_wa = 9;
            cyc(); next();
        end
        mem_valid = 0; iss_valid = 0;
        cyc(); chk("t5_count3", count, 3); chk("t5_busy9", busy[9], 1); next();
        reset = 0; drain_en = 1;
        cyc(); chk("t5_rst_no_we", rf_we, 0); next();
        reset = 1;
        cyc();
        chk("t5_count0", count, 0);
        chk("t5_busy0", busy, 0);
        chk("t5_no_we", rf_we, 0);
        next();

        // T6: youngest queued value is forwarded; r0 never hits
        do_reset();
        alu_valid = 1; alu_wa = 3; alu_wd = 1;
        cyc(); next();
        alu_wd = 2;
        cyc(); next();
        alu_valid = 0; ra0 = 3; ra1 = 0;
        cyc();
`ifdef WBQ_BYPASS_EN
        chk("t6_hit0", fwd0_hit, 1);
        chk("t6_data0", fwd0_data, 2);
        chk("t6_hit1", fwd1_hit, 0);
`else
        chk("t6_nohit0", fwd0_hit, 0);
        chk("t6_nodata0", fwd0_data, 0);
`endif
        next();
        do_reset();

        // Randomized traffic with phases of heavy and light draining
        for (int n = 0; n < 3000; n++) begin
            bit [4:0] w;
            reset     = ($urandom_range(99) != 0);
            alu_valid = 1'($urandom_range(1));
            mem_valid = 1'($urandom_range(1));
            alu_wa    = 5'($urandom_range(7));
            mem_wa    = 5'($urandom_range(7));
            alu_wd    = $urandom;
            mem_wd    = $urandom;
            drain_en  = ((n / 200) % 2 == 0) ? ($urandom_range(3) != 0) : ($urandom_range(3) == 0);
            ra0       = 5'($urandom_range(7));
            ra1       = 5'($urandom_range(7));
            w         = 5'($urandom_range(7, 1));
            iss_wa    = w;
            iss_valid = ($urandom_range(3) == 0) && !m_busy[w];
            cyc(); next();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
